// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the unified-memory miss controller and its arbiter.
package mem_ctrl_pkg;

    // Controller phases: waiting for a miss, writing back a dirty victim,
    // reading the refill line, and one dead cycle for the cache to re-lookup.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StEvict  = 2'd1,
        StFill   = 2'd2,
        StResume = 2'd3
    } state_e;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    // Width of a channel index; never narrower than one bit.
    function automatic int unsigned sel_width(int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Fixed-priority / round-robin arbiter producing a one-hot grant and its index.
// In round-robin mode the search starts at the channel after ptr_i and wraps.
module rr_arbiter import mem_ctrl_pkg::*; #(
    parameter int unsigned NUM_CH = 2,
    localparam int unsigned SEL_W = sel_width(NUM_CH)
) (
    input  logic              mode_i,
    input  logic [NUM_CH-1:0] req_i,
    input  logic [SEL_W-1:0]  ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [SEL_W-1:0]  idx_o,
    output logic              valid_o
);

    int unsigned      cand;
    logic [SEL_W-1:0] cand_idx;
    logic             found;

    // Scan candidates in priority order and take the first requester.
    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        valid_o  = |req_i;
        cand     = 0;
        cand_idx = '0;
        found    = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (mode_i) begin
                cand = (32'(ptr_i) + 32'd1 + k) % NUM_CH;
            end else begin
                cand = k;
            end
            cand_idx = SEL_W'(cand);
            if (!found && req_i[cand_idx]) begin
                found           = 1'b1;
                gnt_o[cand_idx] = 1'b1;
                idx_o           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/mem_miss_ctrl.sv
// Miss / write-back controller sharing one unified memory port among NUM_CH
// cache channels. Dirty victims are written back before the refill read.
module mem_miss_ctrl import mem_ctrl_pkg::*; #(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned ARB_MODE = ARB_FIXED,
    parameter int unsigned TIMEOUT  = 0,
    localparam int unsigned SEL_W   = sel_width(NUM_CH)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_CH-1:0]        req_i,
    input  logic [NUM_CH-1:0]        wr_i,
    input  logic [NUM_CH-1:0]        hit_i,
    input  logic [NUM_CH-1:0]        dirty_i,
    input  logic [NUM_CH*ADDR_W-1:0] miss_addr_i,
    input  logic [NUM_CH*ADDR_W-1:0] evict_addr_i,
    input  logic                     u_rdy_i,
    output logic [NUM_CH-1:0]        rdy_o,
    output logic [NUM_CH-1:0]        cache_we_o,
    output logic [NUM_CH-1:0]        set_dirty_o,
    output logic                     u_re_o,
    output logic                     u_we_o,
    output logic [ADDR_W-1:0]        u_addr_o,
    output logic [SEL_W-1:0]         u_sel_o,
    output logic                     err_o
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CntLimit = CNT_W'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    g_q, g_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   maddr_q, maddr_d;
    logic [ADDR_W-1:0]   eaddr_q, eaddr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SEL_W-1:0]    rr_q, rr_d;
    logic                err_q, err_d;

    logic [NUM_CH-1:0]   miss;
    logic [NUM_CH-1:0]   arb_gnt;
    logic [SEL_W-1:0]    arb_idx;
    logic                arb_valid;
    logic                wr_g;
    logic                dirty_g;

    assign miss    = req_i & ~hit_i;
    assign wr_g    = |(arb_gnt & wr_i);
    assign dirty_g = |(arb_gnt & dirty_i);

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .mode_i  (ARB_MODE == ARB_RR),
        .req_i   (miss),
        .ptr_i   (rr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched transaction, wait counter, round-robin pointer and error pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            g_q     <= '0;
            wr_q    <= 1'b0;
            maddr_q <= '0;
            eaddr_q <= '0;
            cnt_q   <= '0;
            rr_q    <= SEL_W'(NUM_CH - 1);
            err_q   <= 1'b0;
        end else begin
            g_q     <= g_d;
            wr_q    <= wr_d;
            maddr_q <= maddr_d;
            eaddr_q <= eaddr_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath-latch decisions.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        wr_d    = wr_q;
        maddr_d = maddr_q;
        eaddr_d = eaddr_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    g_d     = arb_idx;
                    wr_d    = wr_g;
                    maddr_d = miss_addr_i[32'(arb_idx) * ADDR_W +: ADDR_W];
                    eaddr_d = evict_addr_i[32'(arb_idx) * ADDR_W +: ADDR_W];
                    cnt_d   = '0;
                    state_d = dirty_g ? StEvict : StFill;
                end
            end
            StEvict, StFill: begin
                // A completion on the limit cycle takes precedence over the timeout.
                if (u_rdy_i) begin
                    cnt_d   = '0;
                    state_d = (state_q == StEvict) ? StFill : StResume;
                end else if (TIMEOUT > 0 && cnt_q == CntLimit) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (TIMEOUT > 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StResume: begin
                state_d = StIdle;
                if (ARB_MODE == ARB_RR) begin
                    rr_d = g_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Channel handshakes, cache strobes and memory-port drive.
    always_comb begin
        rdy_o       = ~req_i | ({NUM_CH{state_q == StIdle}} & hit_i);
        cache_we_o  = '0;
        set_dirty_o = '0;
        u_re_o      = 1'b0;
        u_we_o      = 1'b0;
        u_addr_o    = '0;
        u_sel_o     = g_q;
        err_o       = err_q;
        case (state_q)
            StIdle: begin
                cache_we_o  = req_i & wr_i & hit_i;
                set_dirty_o = req_i & wr_i & hit_i;
            end
            StEvict: begin
                u_we_o   = 1'b1;
                u_addr_o = eaddr_q;
            end
            StFill: begin
                u_re_o   = 1'b1;
                u_addr_o = maddr_q;
                if (u_rdy_i) begin
                    cache_we_o[g_q]  = 1'b1;
                    set_dirty_o[g_q] = wr_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mem_miss_ctrl.md
Name: mem_miss_ctrl

Overview:
Parametrised miss/write-back controller that sits between NUM_CH cache channels (I-cache, D-cache, further ports) and the single unified memory port. It arbitrates misses with fixed or round-robin priority, evicts dirty victims before refilling, and drives per-channel ready, cache-write and dirty-bit strobes. A configurable timeout guards against a hung memory.

Parameters:
NUM_CH, 2, number of cache channels; ch0 is highest priority in fixed mode
ADDR_W, 16, line address width on the unified memory port
ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
TIMEOUT, 0, max cycles spent waiting for u_rdy in EVICT or FILL; 0 disables the timeout

Ports:
clk  in  1  system clock; all state updates on its rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NUM_CH  channel i is performing an access this cycle
wr  in  NUM_CH  access on channel i is a store
hit  in  NUM_CH  tag match on channel i
dirty  in  NUM_CH  victim line of channel i is dirty
miss_addr  in  NUM_CH*ADDR_W  refill address; channel i occupies bits [i*ADDR_W +: ADDR_W]
evict_addr  in  NUM_CH*ADDR_W  victim write-back address, same packing as miss_addr
u_rdy  in  1  unified memory has completed the current read or write
rdy  out  NUM_CH  channel i may advance
cache_we  out  NUM_CH  write strobe for cache line or data on channel i
set_dirty  out  NUM_CH  set the dirty bit together with cache_we
u_re  out  1  unified memory read enable
u_we  out  1  unified memory write enable
u_addr  out  ADDR_W  unified memory address
u_sel  out  SEL_W  granted channel index; SEL_W = max(1, clog2(NUM_CH))
err  out  1  one-cycle pulse when a transaction times out

Behaviour:
- States: IDLE, EVICT, FILL, RESUME. Registers: state, grant index g, latched wr_g, latched addresses, wait counter, rr pointer, err.
- Reset (asynchronous, rst_n low):
  - state = IDLE, g = 0, counter = 0, err = 0.
  - rr pointer = NUM_CH-1, so ch0 is granted first.
  - u_re = u_we = 0 and u_addr = 0.
- Miss vector: miss[i] = req[i] & ~hit[i].
- rdy[i] = ~req[i] | (state==IDLE & hit[i]), in every state. Pipeline stall is the AND of rdy, formed outside this block.
- IDLE:
  - For every i with req[i]&wr[i]&hit[i]: cache_we[i] = set_dirty[i] = 1 in the same cycle.
  - If any miss, grant one channel g:
    - ARB_MODE 0: lowest miss index.
    - ARB_MODE 1: first miss index after the rr pointer, wrapping.
  - At grant, latch g, wr[g], miss_addr[g] and evict_addr[g].
  - Next state is EVICT if dirty[g], otherwise FILL.
  - Misses on other channels stay pending; no rdy is given to them.
- EVICT: u_we = 1, u_addr = latched evict address, u_sel = g. On u_rdy, go to FILL and clear the counter.
- FILL: u_re = 1, u_addr = latched miss address, u_sel = g. On u_rdy: cache_we[g] = 1, set_dirty[g] = latched wr, go to RESUME.
- RESUME:
  - One dead cycle; all cache_we = 0 and rdy decoded as a non-IDLE state.
  - Lets the cache re-lookup.
  - Go to IDLE; in RR mode, rr pointer = g.
- Timeout (TIMEOUT > 0):
  - The counter increments each EVICT/FILL cycle without u_rdy.
  - When it reaches TIMEOUT-1 without u_rdy: err pulses next cycle, state goes to IDLE, no cache_we, counter clears.
  - u_rdy in the same cycle as the limit wins; there is no err.
- Boundary rules:
  - req[g] dropping mid-service does not abort; the fill still completes.
  - u_rdy is ignored in IDLE and RESUME.
  - A hit-write on channel j≠g is not serviced until IDLE.
  - Reset mid-transaction aborts immediately; no strobe fires.
- Latency: clean miss = 1 (IDLE) + N_mem (FILL) + 1 (RESUME) cycles before rdy. A dirty miss adds the EVICT memory time.

Decomposition:
- Package mem_ctrl_pkg holds:
  - state enum (IDLE/EVICT/FILL/RESUME, 2 bits);
  - ARB_FIXED / ARB_RR constants;
  - sel_width function.
- Sub-module rr_arbiter (NUM_CH, mode input, request vector, pointer → one-hot grant plus index). It is reusable by other shared-port blocks.

Test Plan:
- NUM_CH=2, all hit, ch1 wr=1 → rdy=2'b11 and cache_we[1]=set_dirty[1]=1 the same cycle; u_re=u_we=0.
- ch0 clean miss at miss_addr 0x0040, u_rdy after 3 cycles → u_re high 3 cycles with u_addr=0x0040; cache_we[0]=1, set_dirty=0; RESUME; rdy[0]=1 on re-hit.
- ch1 dirty write miss, evict_addr 0x1230, miss_addr 0x4560 → EVICT (u_we, 0x1230), then FILL (u_re, 0x4560); cache_we[1]=set_dirty[1]=1.
- ARB_MODE=1, both channels miss continuously → grants alternate 0,1,0,1 across four transactions. With ARB_MODE=0 the same stimulus gives 0 until ch0 hits.
- TIMEOUT=8, u_rdy held low in FILL → err pulses once 8 cycles after FILL entry; state returns to IDLE with no cache_we. Also check that u_rdy on cycle 8 produces no err.
- rst_n asserted mid-EVICT → u_we=0 immediately; after release the first grant goes to ch0.
